// File: rtl/booth_pkg.sv
//==== booth_pkg : shared Booth digit encoding and FSM state types (rev 1.0) ====
`default_nettype none

package booth_pkg;

   localparam int SDN_SINGLE = 2;
   localparam int SDN_DOUBLE = 1;
   localparam int SDN_NEGATE = 0;

   typedef struct packed {
      logic single;
      logic double;
      logic negate;
   } sdn_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } bpa_state_t;

endpackage

`default_nettype wire

// File: rtl/booth_pp_gen.sv
//==== booth_pp_gen : radix-4 Booth partial product (0, +-y, +-2y) (rev 1.0) ====
`default_nettype none

module booth_pp_gen
   import booth_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [2:0]   sdn,
   input  logic [N-1:0] y,
   output logic [N+1:0] pp,
   output logic         illegal
);

   sdn_t         code;
   logic [N+1:0] mag;

   assign code    = '{single: sdn[SDN_SINGLE], double: sdn[SDN_DOUBLE], negate: sdn[SDN_NEGATE]};
   assign illegal = code.single & code.double;

   // Illegal single+double leaves the magnitude at zero, so negate also yields zero.
   always_comb begin
      mag = '0;
      if (code.single && !code.double) begin
         mag = {{2{y[N-1]}}, y};
      end else if (code.double && !code.single) begin
         mag = {y[N-1], y, 1'b0};
      end
      pp = code.negate ? -mag : mag;
   end

endmodule

`default_nettype wire

// File: rtl/booth_pp_accum.sv
//==== booth_pp_accum : sequential radix-4 Booth decoder/accumulator (rev 1.0) ====
`default_nettype none

module booth_pp_accum
   import booth_pkg::*;
#(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load_valid,
   output logic           load_ready,
   input  logic [N-1:0]   y,
   input  logic           digit_valid,
   output logic           digit_ready,
   input  logic [2:0]     sdn,
   input  logic           digit_last,
   output logic           prod_valid,
   input  logic           prod_ready,
   output logic [2*N-1:0] prod,
   output logic           err
);

   localparam int D  = N / 2;
   localparam int W  = 2 * N;
   localparam int KW = (D > 1) ? $clog2(D) : 1;

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_ACCUM = ACCUM;
   localparam logic [1:0] ST_DONE  = DONE;

   logic [1:0]    state;
   logic [N-1:0]  y_q;
   logic [KW-1:0] k;
   logic [W-1:0]  acc;
   logic [W-1:0]  prod_q;
   logic          err_q;

   logic [N+1:0]  pp;
   logic          illegal;
   logic [W-1:0]  pp_ext;
   logic [W-1:0]  shifted;
   logic [W-1:0]  sum;
   logic          last;

   booth_pp_gen #(.N(N)) u_pp_gen (
      .sdn     (sdn),
      .y       (y_q),
      .pp      (pp),
      .illegal (illegal)
   );

   // Sign-extend to the full product width first; bits pushed past 2N by the shift are dropped.
   assign pp_ext  = W'(signed'(pp));
   assign shifted = pp_ext << {k, 1'b0};
   assign sum     = acc + shifted;
   assign last    = digit_last || (k == KW'(D - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         y_q    <= '0;
         k      <= '0;
         acc    <= '0;
         prod_q <= '0;
         err_q  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (load_valid) begin
                  y_q   <= y;
                  acc   <= '0;
                  k     <= '0;
                  err_q <= 1'b0;
                  state <= ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               if (digit_valid) begin
                  acc <= sum;
                  k   <= k + 1'b1;
                  if (illegal) begin
                     err_q <= 1'b1;
                  end
                  if (last) begin
                     prod_q <= sum;
                     state  <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               if (prod_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign load_ready  = (state == ST_IDLE);
   assign digit_ready = (state == ST_ACCUM);
   assign prod_valid  = (state == ST_DONE);
   assign prod        = prod_q;
   assign err         = err_q;

endmodule

`default_nettype wire
